scandoubler: RTL



---
 rtl/scandoubler_pkg.sv | 23 ++
 rtl/sd_line_buffer.sv | 33 +++
 rtl/scandoubler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/scandoubler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scandoubler_pkg
// Brief    : Shared sizing constants, pixel type and address-width helper.
// Revision : 1.0
// ============================================================================
package scandoubler_pkg;

   localparam int c_LINE_MAX_DEFAULT = 1024;
   localparam int c_DW_DEFAULT       = 6;

   typedef struct packed {
      logic [c_DW_DEFAULT-1:0] r;
      logic [c_DW_DEFAULT-1:0] g;
      logic [c_DW_DEFAULT-1:0] b;
   } pixel_t;

   function automatic int addr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : sd_line_buffer
// Brief    : Two-bank simple dual-port line RAM with registered read port.
// Revision : 1.0
// ============================================================================
module sd_line_buffer
   import scandoubler_pkg::*;
#(
   parameter int LINE_MAX = c_LINE_MAX_DEFAULT,
   parameter int WIDTH    = 3 * c_DW_DEFAULT,
   localparam int c_AW    = addr_width(LINE_MAX)
) (
   input  logic             clock,
   input  logic             i_we,
   input  logic [c_AW:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [c_AW:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [0:(2*LINE_MAX)-1];

   // No reset on purpose: keeps the array inferable as block RAM.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/scandoubler.sv
`default_nettype none
// ============================================================================
// Module   : scandoubler
// Brief    : 15 kHz to 31 kHz line doubler with ping-pong buffer and bypass.
// Revision : 1.0
// ============================================================================
module scandoubler
   import scandoubler_pkg::*;
#(
   parameter int LINE_MAX = c_LINE_MAX_DEFAULT,
   parameter int DW       = c_DW_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic          enable,
   input  logic [DW-1:0] r_in,
   input  logic [DW-1:0] g_in,
   input  logic [DW-1:0] b_in,
   input  logic          hs_in,
   input  logic          vs_in,
   output logic [DW-1:0] r_out,
   output logic [DW-1:0] g_out,
   output logic [DW-1:0] b_out,
   output logic          hs_out,
   output logic          vs_out
);

   localparam int            c_AW       = addr_width(LINE_MAX);
   localparam logic [c_AW:0]   c_LINE_MAX = {1'b1, {c_AW{1'b0}}};
   localparam logic [c_AW:0]   c_ONE      = {{c_AW{1'b0}}, 1'b1};
   localparam logic [c_AW-1:0] c_X_ONE    = {{(c_AW-1){1'b0}}, 1'b1};

   logic            r_hs_prev;
   logic            r_vs_prev;
   logic            r_armed;
   logic            r_wbank;
   logic [c_AW:0]   r_in_x;
   logic [c_AW:0]   r_line_len;
   logic [c_AW:0]   r_hs_cnt;
   logic [c_AW:0]   r_hs_w;
   logic [c_AW-1:0] r_out_x;
   logic            r_vs_hold;
   logic            r_active_d1;
   logic            r_hs_d1;
   logic            r_vs_d1;

   logic            w_line_start;
   logic            w_hs_fall;
   logic            w_we;
   logic            w_active;
   logic            w_out_last;
   logic            w_hs_gen;
   logic            w_vs_gen;
   logic [c_AW:0]   w_waddr;
   logic [c_AW:0]   w_raddr;
   logic [3*DW-1:0] w_rdata;

   assign w_line_start = ce_pix & hs_in & ~r_hs_prev;
   assign w_hs_fall    = ce_pix & ~hs_in & r_hs_prev;
   assign w_we         = ce_pix & (w_line_start | (r_in_x != c_LINE_MAX));
   assign w_waddr      = w_line_start ? {~r_wbank, {c_AW{1'b0}}}
                                      : {r_wbank, r_in_x[c_AW-1:0]};
   assign w_raddr      = {~r_wbank, r_out_x};
   assign w_active     = (r_line_len != '0);
   assign w_out_last   = ({1'b0, r_out_x} == (r_line_len - c_ONE));
   assign w_hs_gen     = ({1'b0, r_out_x} < r_hs_w);
   assign w_vs_gen     = (r_out_x == '0) ? r_vs_prev : r_vs_hold;

   sd_line_buffer #(
      .LINE_MAX (LINE_MAX),
      .WIDTH    (3 * DW)
   ) u_line_buffer (
      .clock   (clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata ({r_in, g_in, b_in}),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_hs_prev  <= 1'b0;
         r_vs_prev  <= 1'b0;
         r_armed    <= 1'b0;
         r_wbank    <= 1'b0;
         r_in_x     <= '0;
         r_line_len <= '0;
         r_hs_cnt   <= '0;
         r_hs_w     <= '0;
      end else if (ce_pix) begin
         r_hs_prev <= hs_in;
         r_vs_prev <= vs_in;
         if (w_line_start) begin
            // The first line after reset is partial, so it is never replayed.
            r_line_len <= r_armed ? r_in_x : '0;
            r_armed    <= 1'b1;
            r_wbank    <= ~r_wbank;
            r_in_x     <= c_ONE;
            r_hs_cnt   <= c_ONE;
         end else begin
            if (r_in_x != c_LINE_MAX) begin
               r_in_x <= r_in_x + c_ONE;
            end
            if (hs_in && (r_hs_cnt != c_LINE_MAX)) begin
               r_hs_cnt <= r_hs_cnt + c_ONE;
            end
            if (w_hs_fall) begin
               r_hs_w <= r_hs_cnt;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_x     <= '0;
         r_vs_hold   <= 1'b0;
         r_active_d1 <= 1'b0;
         r_hs_d1     <= 1'b0;
         r_vs_d1     <= 1'b0;
      end else begin
         r_vs_hold   <= w_vs_gen;
         r_active_d1 <= w_active;
         r_hs_d1     <= w_hs_gen;
         r_vs_d1     <= w_vs_gen;
         if (w_line_start || !w_active || w_out_last) begin
            r_out_x <= '0;
         end else begin
            r_out_x <= r_out_x + c_X_ONE;
         end
      end
   end

   // Sync delays above line up with the one-cycle RAM read latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out  <= '0;
         g_out  <= '0;
         b_out  <= '0;
         hs_out <= 1'b0;
         vs_out <= 1'b0;
      end else if (!enable) begin
         if (ce_pix) begin
            r_out  <= r_in;
            g_out  <= g_in;
            b_out  <= b_in;
            hs_out <= hs_in;
            vs_out <= vs_in;
         end
      end else begin
         {r_out, g_out, b_out} <= r_active_d1 ? w_rdata : '0;
         hs_out <= r_active_d1 & r_hs_d1;
         vs_out <= r_active_d1 & r_vs_d1;
      end
   end

endmodule
`default_nettype wire
